// File: rtl/mul_iter_unit_pkg.sv
// Shared constants for the iterative multiply / multiply-accumulate unit:
// word width, the all-zero word and the state encodings.
package mul_iter_unit_pkg;

   localparam int WordWidth = 32;
   localparam logic [WordWidth-1:0] WordZero = '0;

   // State encodings kept as plain constants so older tools can consume them
   localparam logic [1:0] MulIdle = 2'd0;
   localparam logic [1:0] MulRun  = 2'd1;
   localparam logic [1:0] MulDone = 2'd2;

endpackage

// File: rtl/mul_iter_unit_if.sv
// Bundle of the request/response signals of mul_iter_unit together with the
// shared word-adder operand/sum path it borrows while busy.
interface mul_iter_unit_if;
   import mul_iter_unit_pkg::*;

   logic                 in_Start;
   logic                 in_Accumulate;
   logic [WordWidth-1:0] in_Multiplicand;
   logic [WordWidth-1:0] in_Multiplier;
   logic [WordWidth-1:0] in_Accumulator;
   logic                 out_Busy;
   logic                 out_Done;
   logic [WordWidth-1:0] out_Result;
   logic                 out_Zero;
   logic                 out_Neg;
   logic [WordWidth-1:0] out_AddLeft;
   logic [WordWidth-1:0] out_AddRight;
   logic                 out_AddLowCarry;
   logic [WordWidth-1:0] in_AddResult;

   // The multiply unit itself
   modport slave (
      input  in_Start, in_Accumulate, in_Multiplicand, in_Multiplier,
             in_Accumulator, in_AddResult,
      output out_Busy, out_Done, out_Result, out_Zero, out_Neg,
             out_AddLeft, out_AddRight, out_AddLowCarry
   );

   // The requester side, which also closes the loop through the word adder
   modport master (
      output in_Start, in_Accumulate, in_Multiplicand, in_Multiplier,
             in_Accumulator, in_AddResult,
      input  out_Busy, out_Done, out_Result, out_Zero, out_Neg,
             out_AddLeft, out_AddRight, out_AddLowCarry
   );

endinterface

// File: rtl/mul_iter_unit.sv
// Iterative shift-and-add multiplier (MUL/MLA). Each RUN cycle feeds the
// external word adder with P and (Q[0] ? M : 0) and captures the sum back
// into P. Stops as soon as the remaining multiplier bits are all zero.
module mul_iter_unit
   import mul_iter_unit_pkg::*;
(
   input  logic           clock,
   input  logic           reset,
   mul_iter_unit_if.slave bus
);

   logic [1:0]           r_state;
   logic [WordWidth-1:0] r_p;
   logic [WordWidth-1:0] r_m;
   logic [WordWidth-1:0] r_q;
   logic [WordWidth-1:0] r_result;
   logic                 r_zero;
   logic                 r_neg;

   logic                 w_run;
   logic [WordWidth-1:0] w_q_next;
   logic                 w_last;

   assign w_run    = (r_state == MulRun);
   assign w_q_next = r_q >> 1;
   // Terminate once no set multiplier bits remain beyond the current one
   assign w_last   = (w_q_next == WordZero);

   // Adder operands are only driven while iterating; quiet otherwise so the
   // shared adder mux sees zeros from this side
   assign bus.out_AddLeft     = w_run ? r_p : WordZero;
   assign bus.out_AddRight    = (w_run && r_q[0]) ? r_m : WordZero;
   assign bus.out_AddLowCarry = 1'b0;

   assign bus.out_Busy   = w_run;
   assign bus.out_Done   = (r_state == MulDone);
   assign bus.out_Result = r_result;
   assign bus.out_Zero   = r_zero;
   assign bus.out_Neg    = r_neg;

   // Sequencer and datapath: load on accepted start, shift/accumulate in RUN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state  <= MulIdle;
         r_p      <= WordZero;
         r_m      <= WordZero;
         r_q      <= WordZero;
         r_result <= WordZero;
         r_zero   <= 1'b1;
         r_neg    <= 1'b0;
      end else begin
         case (r_state)
            MulIdle, MulDone: begin
               if (bus.in_Start) begin
                  r_p     <= bus.in_Accumulate ? bus.in_Accumulator : WordZero;
                  r_m     <= bus.in_Multiplicand;
                  r_q     <= bus.in_Multiplier;
                  r_state <= MulRun;
               end else begin
                  r_state <= MulIdle;
               end
            end
            MulRun: begin
               r_p <= bus.in_AddResult;
               r_m <= r_m << 1;
               r_q <= w_q_next;
               if (w_last) begin
                  r_result <= bus.in_AddResult;
                  r_zero   <= (bus.in_AddResult == WordZero);
                  r_neg    <= bus.in_AddResult[WordWidth-1];
                  r_state  <= MulDone;
               end
            end
            default: r_state <= MulIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_iter_unit.sv
// Scoreboard bench for mul_iter_unit: stimulus pushes the arithmetic
// expectation, a monitor pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_mul_iter_unit;
   import mul_iter_unit_pkg::*;

   typedef struct {
      logic [31:0] res;
      logic        z;
      logic        n;
      int          k;
      int          lat;
   } exp_t;

   logic clock;
   logic reset;
   int   cyc;
   int   checks;
   int   errors;
   exp_t sb[$];

   mul_iter_unit_if bus ();

   mul_iter_unit dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Behavioural word adder closing the loop
   assign bus.in_AddResult = bus.out_AddLeft + bus.out_AddRight + {31'd0, bus.out_AddLowCarry};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   // Reference: arithmetic result and iteration count from the operand bits
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] c, input logic acc);
      exp_t e;
      longint unsigned full;
      int hi;
      full = longint'(a) * longint'(b) + (acc ? longint'(c) : 64'd0);
      e.res = full[31:0];
      e.z = (e.res == 32'd0);
      e.n = e.res[31];
      hi = -1;
      for (int i = 0; i < 32; i++) if (b[i]) hi = i;
      e.lat = (hi < 0) ? 1 : hi + 1;
      e.k = 0;
      return e;
   endfunction

   // Called at a negedge; waits for the unit to accept, then issues one op
   task automatic issue(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic acc);
      exp_t e;
      int guard;
      guard = 0;
      while (bus.out_Busy && guard < 100) begin
         @(negedge clock);
         guard++;
      end
      if (guard >= 100) check("issue_wait_timeout", 32'd1, 32'd0);
      bus.in_Multiplicand = a;
      bus.in_Multiplier   = b;
      bus.in_Accumulator  = c;
      bus.in_Accumulate   = acc;
      bus.in_Start        = 1'b1;
      e = model(a, b, c, acc);
      e.k = cyc + 1;
      sb.push_back(e);
      $display("issue a=0x%08h b=0x%08h c=0x%08h acc=%0d exp=0x%08h lat=%0d",
               a, b, c, acc, e.res, e.lat);
      @(negedge clock);
      bus.in_Start = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 200) begin
         @(negedge clock);
         guard++;
      end
      if (guard >= 200) check("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   // Monitor: adder drive quiet outside RUN, and result check on done
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset) begin
            if (!bus.out_Busy)
               check("add_idle_quiet", bus.out_AddLeft | bus.out_AddRight, 32'd0);
            check("add_carry", {31'd0, bus.out_AddLowCarry}, 32'd0);
            if (bus.out_Done) begin
               if (sb.size() == 0) begin
                  check("unexpected_done", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  check("result", bus.out_Result, e.res);
                  check("zero", {31'd0, bus.out_Zero}, {31'd0, e.z});
                  check("neg", {31'd0, bus.out_Neg}, {31'd0, e.n});
                  check("latency", 32'(cyc - e.k), 32'(e.lat));
                  check("busy_in_done", {31'd0, bus.out_Busy}, 32'd0);
                  $display("done result=0x%08h z=%0d n=%0d lat=%0d", bus.out_Result,
                           bus.out_Zero, bus.out_Neg, cyc - e.k);
               end
            end
         end
      end
   end

   task automatic check_reset_values(input string tag);
      check({tag, "_result"}, bus.out_Result, 32'd0);
      check({tag, "_zero"}, {31'd0, bus.out_Zero}, 32'd1);
      check({tag, "_neg"}, {31'd0, bus.out_Neg}, 32'd0);
      check({tag, "_busy"}, {31'd0, bus.out_Busy}, 32'd0);
      check({tag, "_done"}, {31'd0, bus.out_Done}, 32'd0);
      check({tag, "_addleft"}, bus.out_AddLeft, 32'd0);
      check({tag, "_addright"}, bus.out_AddRight, 32'd0);
   endtask

   initial begin
      logic [31:0] a, b, c;
      cyc = 0;
      checks = 0;
      errors = 0;
      bus.in_Start = 1'b0;
      bus.in_Accumulate = 1'b0;
      bus.in_Multiplicand = '0;
      bus.in_Multiplier = '0;
      bus.in_Accumulator = '0;
      reset = 1'b1;
      #1 reset = 1'b0;
      #2 check_reset_values("reset");
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      // Directed cases
      issue(32'd3, 32'd5, 32'd0, 1'b0);
      issue(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0);
      issue(32'd2, 32'd3, 32'd7, 1'b1);
      issue(32'h12345678, 32'd0, 32'h55, 1'b0);
      issue(32'd0, 32'd0, 32'h80000000, 1'b1);
      issue(32'h80000000, 32'd1, 32'd0, 1'b0);
      drain();

      // Start while busy is ignored
      issue(32'd7, 32'hF0000000, 32'd0, 1'b0);
      repeat (4) @(negedge clock);
      bus.in_Multiplicand = 32'd9;
      bus.in_Multiplier   = 32'd3;
      bus.in_Accumulate   = 1'b1;
      bus.in_Accumulator  = 32'd1;
      bus.in_Start        = 1'b1;
      @(negedge clock);
      bus.in_Start = 1'b0;
      drain();

      // Reset mid-RUN aborts without a done pulse
      issue(32'd7, 32'hF0000000, 32'd0, 1'b0);
      repeat (9) @(negedge clock);
      check("busy_before_abort", {31'd0, bus.out_Busy}, 32'd1);
      reset = 1'b0;
      void'(sb.pop_back());
      #1 check_reset_values("abort");
      @(negedge clock);
      reset = 1'b1;
      repeat (35) @(negedge clock);
      issue(32'd6, 32'd7, 32'd0, 1'b0);
      drain();

      // Randomized traffic with varied multiplier widths and issue gaps
      for (int i = 0; i < 60; i++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 9) == 0) b = 32'd0;
         c = $urandom;
         issue(a, b, c, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) @(negedge clock);
      end
      drain();
      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time bound so the run always terminates
   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mul_iter_unit.md
# mul_iter_unit

Iterative 32-bit multiply / multiply-accumulate unit for the ARM MUL/MLA datapath. It sits directly in front of the shared 32-bit word adder. Each cycle it drives the adder's operand inputs with a partial product and a shifted multiplicand, then captures the adder's sum as the next partial product. It returns the low 32 bits of A×B (+C) with N/Z flags and a one-cycle done pulse.

## Interface
Parameters:
- `WordWidth`, 32: operand and result width. Taken from the shared package; this block is built and verified only at 32.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_Start`  in  1  start request; sampled only when `out_Busy`=0.
- `in_Accumulate`  in  1  1 = MLA (add `in_Accumulator`), 0 = MUL; sampled with start.
- `in_Multiplicand`  in  32  operand A; sampled with start.
- `in_Multiplier`  in  32  operand B; sampled with start.
- `in_Accumulator`  in  32  operand C; sampled with start.
- `out_Busy`  out  1  high in the RUN state.
- `out_Done`  out  1  one-cycle pulse; result and flags are valid in that cycle.
- `out_Result`  out  32  (A×B + C) mod 2^32; held until the next accepted start.
- `out_Zero`  out  1  `out_Result` == 0; registered with the result.
- `out_Neg`  out  1  `out_Result[31]`; registered with the result.
- `out_AddLeft`  out  32  adder left operand, driven combinationally.
- `out_AddRight`  out  32  adder right operand, driven combinationally.
- `out_AddLowCarry`  out  1  adder carry-in; constant 0.
- `in_AddResult`  in  32  adder sum; combinational return in the same cycle.

## Operation
- Internal registers: P (partial product, 32 bits), M (shifted multiplicand, 32 bits), Q (shifted multiplier, 32 bits), 2-bit state.
- **IDLE**
  - `in_Start`=1 loads P ← `in_Accumulate` ? C : 0, M ← A, Q ← B, then goes to RUN.
- **RUN**
  - Combinational drive: `out_AddLeft` = P; `out_AddRight` = Q[0] ? M : 0.
  - At each edge: P ← `in_AddResult`; M ← M<<1 (MSB dropped); Q ← Q>>1 (zero fill).
  - If the next Q is 0, latch `out_Result` = `in_AddResult` along with `out_Zero` and `out_Neg`, then go to DONE.
  - Iterations per operation n = max(1, index of highest set bit of B + 1), so 1..32. Early termination is mandatory.
- **DONE**
  - `out_Done`=1 and `out_Busy`=0 for exactly one cycle, then IDLE.
  - `in_Start` is accepted in DONE, with the same behaviour as in IDLE.
- Outside RUN, `out_AddLeft`, `out_AddRight` and `out_AddLowCarry` are all 0.
- Adder carry-out and overflow are not consumed. MUL does not produce C or V here; flag merge happens downstream.
- `in_Start` while `out_Busy`=1 is ignored and the operation in flight is unaffected.
- Reset asserted at any time, including mid-RUN:
  - state → IDLE;
  - P, M, Q, `out_Result` → 0;
  - `out_Zero` → 1, `out_Neg` → 0, `out_Busy` → 0, `out_Done` → 0.
  - No done pulse is issued for the aborted operation.

## Timing
- Start accepted at edge k. `out_Busy` is high from after edge k to after edge k+n.
- `out_Done` is high during the cycle between edges k+n and k+n+1.
- Latency from the start edge to done is n cycles. The minimum issue interval is n+1 cycles.
- The adder path is a single-cycle combinational loop: out_Add* → adder → `in_AddResult` → P. It must close timing within one clock.
- Operand inputs need be stable only at the start edge.

## Structure
- Shared package holds:
  - `WordWidth` and `WordZero`;
  - the state encodings `MulIdle`, `MulRun`, `MulDone`.
- No sub-module. The word adder is an external peer, instantiated once at the execute-stage level and muxed between the ALU and this unit by `out_Busy`.
- The bench instantiates a behavioural 32-bit adder to close the loop.

## Test plan
- MUL A=3, B=5 → `out_Result`=15, Z=0, N=0. `out_Done` 3 cycles after the start edge.
- MUL A=0xFFFFFFFF, B=0xFFFFFFFF → result 0x00000001, N=0. Latency 32.
- MLA A=2, B=3, C=7 → result 13, latency 2.
- MUL with B=0 → result 0, Z=1, latency 1.
- MLA A=0, B=0, C=0x80000000 → result 0x80000000, N=1, latency 1.
- MUL A=0x80000000, B=1 → result 0x80000000, N=1, latency 1.
- Start A=7, B=0xF0000000; pulse `in_Start` with new operands on cycle 5 → the second start is ignored; result 0x90000000 at latency 32.
- Start A=7, B=0xF0000000; assert `reset` on cycle 10 → no `out_Done`, outputs at reset values. A new MUL 6×7 afterwards → 42.
